// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer.
//   fib_state_e : controller state encoding (IDLE, RUN, DONE)
//   FIB_W       : width of the terms c/n and of the i output
//   FIB_MAX_IDX : largest index the sequencer will compute; larger requests clamp here
//   FIB_IDX_W   : width of the index registers and of req_n
package fib_pkg;

    localparam int unsigned FIB_W       = 11;
    localparam int unsigned FIB_MAX_IDX = 30;
    localparam int unsigned FIB_IDX_W   = 5;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } fib_state_e;

endpackage

// File: rtl/fib_dp.sv
// Fibonacci datapath: index, current term, next term and the term adder.
// Build option: FIB_SAT_EN makes an overflowing sum saturate to all-ones;
// without it the sum wraps modulo 2**FIB_W.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears all registers)
//   load     : start a job (idx=0, cur=0, nxt=1)
//   step     : advance one term (cur<=nxt, nxt<=cur+nxt, idx<=idx+1)
//   idx      : current index
//   cur, nxt : current term F(idx) and next term F(idx+1)
//   carry    : the cur+nxt addition carries out of the top bit this cycle
module fib_dp
    import fib_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    output logic [FIB_IDX_W-1:0] idx,
    output logic [FIB_W-1:0]     cur,
    output logic [FIB_W-1:0]     nxt,
    output logic                 carry
);

    logic [FIB_IDX_W-1:0] idx_q;
    logic [FIB_W-1:0]     cur_q;
    logic [FIB_W-1:0]     nxt_q;
    logic [FIB_W:0]       sum;
    logic [FIB_W-1:0]     nxt_step;

    assign sum   = {1'b0, cur_q} + {1'b0, nxt_q};
    assign carry = sum[FIB_W];

    always_comb begin
`ifdef FIB_SAT_EN
        nxt_step = carry ? {FIB_W{1'b1}} : sum[FIB_W-1:0];
`else
        nxt_step = sum[FIB_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            cur_q <= '0;
            nxt_q <= '0;
        end else if (load) begin
            idx_q <= '0;
            cur_q <= '0;
            nxt_q <= FIB_W'(1);
        end else if (step) begin
            idx_q <= idx_q + FIB_IDX_W'(1);
            cur_q <= nxt_q;
            nxt_q <= nxt_step;
        end
    end

    assign idx = idx_q;
    assign cur = cur_q;
    assign nxt = nxt_q;

endmodule

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequence controller: accepts a target index T, steps the datapath
// while selector is high and presents F(T) with a valid/ready handshake.
// Build option: FIB_SAT_EN selects saturating instead of wrapping term arithmetic.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   selector              : advance enable while running (0 = stall)
//   req_valid, req_n      : job request and target index (clamped to FIB_MAX_IDX)
//   req_ready             : controller idle and able to accept a job
//   resp_valid, resp_ready: result handshake
//   resp_data, resp_ovf   : result term and overflow flag (zero unless resp_valid)
//   i, c, n               : live view of the index, current term and next term
module fib_seq_ctrl
    import fib_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 selector,
    input  logic                 req_valid,
    input  logic [FIB_IDX_W-1:0] req_n,
    output logic                 req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [FIB_W-1:0]     resp_data,
    output logic                 resp_ovf,
    output logic [FIB_W-1:0]     i,
    output logic [FIB_W-1:0]     c,
    output logic [FIB_W-1:0]     n
);

    fib_state_e           state_q, state_d;
    logic [FIB_IDX_W-1:0] target_q;
    logic [FIB_IDX_W-1:0] target_clamped;
    logic                 pend_q;
    logic                 ovf_q;
    logic                 load;
    logic                 step;
    logic [FIB_IDX_W-1:0] idx;
    logic [FIB_W-1:0]     cur;
    logic [FIB_W-1:0]     nxt;
    logic                 carry;

    fib_dp u_dp (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .idx   (idx),
        .cur   (cur),
        .nxt   (nxt),
        .carry (carry)
    );

    assign target_clamped = (req_n > FIB_IDX_W'(FIB_MAX_IDX)) ? FIB_IDX_W'(FIB_MAX_IDX) : req_n;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (selector) begin
                    if (idx == target_q) begin
                        state_d = StDone;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            StDone: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The term in nxt runs one addition ahead of the result. A carry is first
    // recorded as pending against nxt and only becomes the reported overflow
    // once that inexact term moves into cur, so a look-ahead addition that never
    // reaches the result does not flag it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            target_q <= '0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                target_q <= target_clamped;
                pend_q   <= 1'b0;
                ovf_q    <= 1'b0;
            end else if (step) begin
                ovf_q  <= ovf_q | pend_q;
                pend_q <= pend_q | carry;
            end
        end
    end

    // Gated with rst so an aborted job is never presented, even combinationally.
    assign req_ready  = (state_q == StIdle) && !rst;
    assign resp_valid = (state_q == StDone) && !rst;
    assign resp_data  = resp_valid ? cur : '0;
    assign resp_ovf   = resp_valid & ovf_q;

    assign i = FIB_W'(idx);
    assign c = cur;
    assign n = nxt;

endmodule
